// File: rtl/hdb3_pkg.sv
// rtl/hdb3_pkg.sv - HDB3 symbol encodings and line-code constants shared by the transmit and receive sides
package hdb3_pkg;

  localparam logic [1:0] HDB3_SYM_ZERO = 2'b00;
  localparam logic [1:0] HDB3_SYM_NEG  = 2'b01;
  localparam logic [1:0] HDB3_SYM_POS  = 2'b10;
  localparam logic [1:0] HDB3_SYM_ILL  = 2'b11;

  localparam int HDB3_ZRUN_MAX  = 3;
  localparam int HDB3_DEC_DEPTH = 4;

  typedef enum logic {
    POL_NEG = 1'b0,
    POL_POS = 1'b1
  } hdb3_pol_e;

endpackage

// File: rtl/hdb3_err_counter.sv
// rtl/hdb3_err_counter.sv - saturating error counter; a clear in the same cycle as an increment wins
module hdb3_err_counter #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [ERR_W-1:0] cnt_o
);

  logic [ERR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {ERR_W{1'b1}})) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hdb3_decoder.sv
// rtl/hdb3_decoder.sv - HDB3 receive decoder: strips 000V/B00V substitutions and flags line-code errors
module hdb3_decoder
  import hdb3_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bp_i,
  input  logic             bn_i,
  input  logic             clr_err_i,
  output logic             data_out_o,
  output logic             data_valid_o,
  output logic             code_err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam logic [1:0] ZRUN_MAX = 2'(HDB3_ZRUN_MAX);
  localparam logic [2:0] FILL_MAX = 3'(HDB3_DEC_DEPTH);

  logic       bp_q, bn_q;
  logic [3:0] sr_q, sr_d;
  logic [1:0] zrun_q, zrun_d;
  logic [2:0] fill_q, fill_d;
  hdb3_pol_e  last_pol_q, last_pol_d;
  hdb3_pol_e  last_v_pol_q, last_v_pol_d;
  logic       v_seen_q, v_seen_d;
  logic       code_err_q, valid_q;

  logic       is_mark, is_ill, is_v, err_d;
  hdb3_pol_e  mark_pol;

  always_comb begin
    is_mark  = 1'b0;
    is_ill   = 1'b0;
    mark_pol = POL_POS;
    case ({bp_q, bn_q})
      HDB3_SYM_POS:  begin is_mark = 1'b1; mark_pol = POL_POS; end
      HDB3_SYM_NEG:  begin is_mark = 1'b1; mark_pol = POL_NEG; end
      HDB3_SYM_ILL:  is_ill = 1'b1;
      HDB3_SYM_ZERO: is_ill = 1'b0;
      default:       is_ill = 1'b0;
    endcase

    // A mark repeating the previous mark's polarity is a substitution violation
    is_v = is_mark && (mark_pol == last_pol_q);

    err_d = is_ill
          || (!is_mark && (zrun_q == ZRUN_MAX))
          || (is_v && v_seen_q && (mark_pol == last_v_pol_q));

    // On a V the bit three symbols back (B of B00V, or a 0 of 000V) is cleared
    if (is_v) begin
      sr_d = {1'b0, sr_q[1], sr_q[0], 1'b0};
    end else begin
      sr_d = {sr_q[2:0], is_mark};
    end

    if (is_mark) begin
      zrun_d = '0;
    end else if (zrun_q == ZRUN_MAX) begin
      zrun_d = zrun_q;
    end else begin
      zrun_d = zrun_q + 2'd1;
    end

    last_pol_d   = is_mark ? mark_pol : last_pol_q;
    last_v_pol_d = is_v ? mark_pol : last_v_pol_q;
    v_seen_d     = v_seen_q | is_v;
    fill_d       = (fill_q == FILL_MAX) ? fill_q : fill_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_q         <= 1'b0;
      bn_q         <= 1'b0;
      sr_q         <= '0;
      zrun_q       <= '0;
      fill_q       <= '0;
      last_pol_q   <= POL_POS;
      last_v_pol_q <= POL_POS;
      v_seen_q     <= 1'b0;
      code_err_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      bp_q         <= bp_i;
      bn_q         <= bn_i;
      sr_q         <= sr_d;
      zrun_q       <= zrun_d;
      fill_q       <= fill_d;
      last_pol_q   <= last_pol_d;
      last_v_pol_q <= last_v_pol_d;
      v_seen_q     <= v_seen_d;
      code_err_q   <= err_d;
      valid_q      <= (fill_d == FILL_MAX);
    end
  end

  hdb3_err_counter #(
    .ERR_W(ERR_W)
  ) u_err_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(err_d),
    .clr_i(clr_err_i),
    .cnt_o(err_cnt_o)
  );

  assign data_out_o   = sr_q[3];
  assign data_valid_o = valid_q;
  assign code_err_o   = code_err_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// tb/tb_hdb3_decoder.sv - directed table plus randomized stream checked against a history-based HDB3 model
module tb_hdb3_decoder;
  import hdb3_pkg::*;

  localparam int ERR_W   = 2;
  localparam int CNT_MAX = (1 << ERR_W) - 1;
  localparam int MAXE    = 4096;
  localparam logic [1:0] SZ = HDB3_SYM_ZERO;
  localparam logic [1:0] SN = HDB3_SYM_NEG;
  localparam logic [1:0] SP = HDB3_SYM_POS;
  localparam logic [1:0] SI = HDB3_SYM_ILL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bp_i = 1'b0, bn_i = 1'b0, clr_err_i = 1'b0;
  logic data_out_o, data_valid_o, code_err_o;
  logic [ERR_W-1:0] err_cnt_o;

  hdb3_decoder #(.ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bp_i        (bp_i),
    .bn_i        (bn_i),
    .clr_err_i   (clr_err_i),
    .data_out_o  (data_out_o),
    .data_valid_o(data_valid_o),
    .code_err_o  (code_err_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sym;
    logic       clr;
    logic       dout;
    logic       cerr;
    int         cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   e;
  int   m_cnt;
  logic [1:0] sym_h [0:MAXE];
  bit         isv_h [0:MAXE];
  bit         nrm_h [0:MAXE];
  logic x_dout, x_cerr, x_valid;
  int   x_cnt;

  function automatic bit is_mark(input logic [1:0] s);
    return (s == SP) || (s == SN);
  endfunction

  task automatic add(input logic [1:0] s, input logic c, input logic d, input logic ce, input int n);
    vec_t v;
    v.sym = s; v.clr = c; v.dout = d; v.cerr = ce; v.cnt = n;
    tbl.push_back(v);
  endtask

  task automatic seg_start();
    e = 0;
    sym_h[0] = SZ;
    m_cnt = 0;
  endtask

  // Expected outputs after edge e, derived from the whole symbol history since reset
  task automatic model_edge(input logic c);
    int k, run;
    logic [1:0] s;
    bit mk, pol, lp, v, errc, err;
    k = e - 1;
    s = sym_h[k];
    mk = is_mark(s);
    pol = (s == SP);
    lp = 1'b1;
    for (int j = k - 1; j >= 0; j--) if (is_mark(sym_h[j])) begin lp = (sym_h[j] == SP); break; end
    v = mk && (pol == lp);
    run = 0;
    if (!mk) for (int j = k; j >= 0; j--) begin if (is_mark(sym_h[j])) break; run++; end
    errc = 1'b0;
    if (v) for (int j = k - 1; j >= 0; j--) if (isv_h[j]) begin errc = (sym_h[j] == s); break; end
    err = (s == SI) || (run >= 4) || errc;
    isv_h[k] = v;
    nrm_h[k] = mk && !v;
    if (c) m_cnt = 0;
    else if (err && m_cnt < CNT_MAX) m_cnt++;
    x_cerr  = err;
    x_cnt   = m_cnt;
    x_valid = (e >= 4);
    x_dout  = (e >= 4) ? (nrm_h[e-4] && !isv_h[e-1]) : 1'b0;
  endtask

  task automatic step(input logic [1:0] s, input logic c);
    bp_i = s[1];
    bn_i = s[0];
    clr_err_i = c;
    @(posedge clk);
    if (e < MAXE) e++;
    sym_h[e] = s;
    model_edge(c);
    #1;
  endtask

  task automatic check(input string name, input logic d, input logic ce, input int n, input logic vl);
    n_vec++;
    if (data_out_o !== d || code_err_o !== ce || err_cnt_o !== n[ERR_W-1:0] || data_valid_o !== vl) begin
      n_mis++;
      $display("FAIL %s e=%0d got dout=%0b cerr=%0b cnt=%0d valid=%0b want dout=%0b cerr=%0b cnt=%0d valid=%0b",
               name, e, data_out_o, code_err_o, err_cnt_o, data_valid_o, d, ce, n, vl);
    end
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 check("async_reset", 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1 check("reset_hold", 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    seg_start();
  endtask

  initial begin
    logic [1:0] rs;
    int r;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bp_i = 1'($urandom); bn_i = 1'($urandom); clr_err_i = 1'($urandom);
    end
    @(posedge clk);
    #1 check("reset", 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    seg_start();

    // marks, 000V, B00V, illegal + clear, zero run, equal-polarity V's, saturation
    add(SN,0,0,0,0); add(SP,0,0,0,0); add(SN,0,0,0,0); add(SP,0,0,0,0);
    add(SN,0,1,0,0); add(SP,0,1,0,0); add(SZ,0,1,0,0); add(SZ,0,1,0,0);
    add(SZ,0,1,0,0); add(SP,0,1,0,0); add(SN,0,0,0,0); add(SP,0,0,0,0);
    add(SN,0,0,0,0); add(SZ,0,0,0,0); add(SZ,0,1,0,0); add(SN,0,1,0,0);
    add(SP,0,0,0,0); add(SZ,0,0,0,0); add(SI,0,0,0,0); add(SN,0,0,1,1);
    add(SI,0,1,0,1); add(SP,1,0,1,0); add(SZ,0,0,0,0); add(SZ,0,1,0,0);
    add(SZ,0,0,0,0); add(SZ,0,1,0,0); add(SZ,0,0,1,1); add(SN,0,0,1,2);
    add(SN,0,0,0,2); add(SZ,0,0,1,3); add(SN,0,0,0,3); add(SI,0,0,1,3);
    add(SP,0,0,1,3); add(SN,0,0,0,3); add(SP,0,0,0,3); add(SN,0,0,0,3);
    add(SZ,0,1,0,3); add(SZ,0,1,0,3); add(SZ,0,1,0,3); add(SZ,0,1,0,3);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sym, tbl[i].clr);
      check("table", tbl[i].dout, tbl[i].cerr, tbl[i].cnt, (i + 1) >= 4);
    end

    async_reset();

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) async_reset();
      r = $urandom_range(0, 99);
      if (r < 40) rs = SZ;
      else if (r < 95) rs = ($urandom_range(0, 1) == 1) ? SP : SN;
      else rs = SI;
      step(rs, $urandom_range(0, 31) == 0);
      check("random", x_dout, x_cerr, x_cnt, x_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
